// File: rtl/geofence_pkg.sv
// Shared state encoding, vertex-count limits and arithmetic sizing for the
// geofence point-in-polygon classifier.
package geofence_pkg;

    typedef enum logic [1:0] {LOAD, SORT, CHECK, DONE} state_t;

    localparam int NV_MIN = 3;
    localparam int NV_MAX = 8;

    // Two (W+1)-bit differences multiplied give 2W+2 bits; their difference needs one more.
    function automatic int cross_w(input int w);
        return 2 * w + 3;
    endfunction

endpackage

// File: rtl/geofence_cross.sv
// Signed cross product of (a - o) and (b - o) for unsigned W-bit points,
// carried at full precision so the sign and the zero case are exact.
module geofence_cross
    import geofence_pkg::*;
#(
    parameter int W = 10
) (
    input  logic [W-1:0]                 i_ox,
    input  logic [W-1:0]                 i_oy,
    input  logic [W-1:0]                 i_ax,
    input  logic [W-1:0]                 i_ay,
    input  logic [W-1:0]                 i_bx,
    input  logic [W-1:0]                 i_by,
    output logic signed [cross_w(W)-1:0] o_c
);

    localparam int PW = 2 * W + 2;

    logic signed [W:0]    w_dax, w_day, w_dbx, w_dby;
    logic signed [PW-1:0] w_p1, w_p2;

    assign w_dax = $signed({1'b0, i_ax}) - $signed({1'b0, i_ox});
    assign w_day = $signed({1'b0, i_ay}) - $signed({1'b0, i_oy});
    assign w_dbx = $signed({1'b0, i_bx}) - $signed({1'b0, i_ox});
    assign w_dby = $signed({1'b0, i_by}) - $signed({1'b0, i_oy});

    assign w_p1 = $signed({{(W+1){w_dax[W]}}, w_dax}) * $signed({{(W+1){w_dby[W]}}, w_dby});
    assign w_p2 = $signed({{(W+1){w_dbx[W]}}, w_dbx}) * $signed({{(W+1){w_day[W]}}, w_day});

    assign o_c = $signed({w_p1[PW-1], w_p1}) - $signed({w_p2[PW-1], w_p2});

endmodule

// File: rtl/geofence_gen.sv
// Point-in-convex-polygon classifier: loads a test point and NV vertices,
// sorts the vertices clockwise around V1, then tests every edge against P.
module geofence_gen
    import geofence_pkg::*;
#(
    parameter int W           = 10,
    parameter int NV          = 6,
    parameter bit EDGE_INSIDE = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    output logic         busy,
    output logic         valid,
    output logic         is_inside,
    output logic         on_edge
);

    localparam int IW = $clog2(NV_MAX);
    localparam int CW = $clog2(NV_MAX + 1);
    localparam int XW = cross_w(W);

    state_t r_state, w_next;

    logic [W-1:0]  r_px, r_py;
    logic [W-1:0]  r_vx [NV];
    logic [W-1:0]  r_vy [NV];
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_i, r_j;   // sort indices offset by NV_MIN (i = r_i + 3)
    logic [IW-1:0] r_k;
    logic          r_out_f, r_edge_f;
    logic          r_inside, r_on_edge;

    logic [IW-1:0]        w_ia, w_ib;
    logic [W-1:0]         w_ox, w_oy, w_ax, w_ay, w_bx, w_by;
    logic signed [XW-1:0] w_c;
    logic                 w_load_last, w_sort_last, w_check_last;
    logic                 w_in_box, w_out_nx, w_edge_nx;

    assign w_load_last  = (r_state == LOAD) && in_valid && (r_cnt == CW'(NV));
    assign w_sort_last  = (r_state == SORT) && (r_i == CW'(NV - NV_MIN)) && (r_j == '0);
    assign w_check_last = (r_state == CHECK) && (r_k == IW'(NV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= LOAD;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        valid  = 1'b0;
        case (r_state)
            LOAD: begin
                busy = 1'b0;
                if (w_load_last) w_next = SORT;
            end
            SORT:    if (w_sort_last) w_next = CHECK;
            CHECK:   if (w_check_last) w_next = DONE;
            default: begin
                valid  = 1'b1;
                w_next = LOAD;
            end
        endcase
    end

    // SORT compares the adjacent pair (Vj-1, Vj) around V1; CHECK walks edge Vk -> Vk+1 around P.
    always_comb begin
        w_ia = IW'(r_j + CW'(1));
        w_ib = IW'(r_j + CW'(2));
        w_ox = r_vx[0];
        w_oy = r_vy[0];
        if (r_state == CHECK) begin
            w_ia = r_k;
            w_ib = (r_k == IW'(NV - 1)) ? '0 : r_k + IW'(1);
            w_ox = r_px;
            w_oy = r_py;
        end
    end

    assign w_ax = r_vx[w_ia];
    assign w_ay = r_vy[w_ia];
    assign w_bx = r_vx[w_ib];
    assign w_by = r_vy[w_ib];

    geofence_cross #(.W(W)) u_cross (
        .i_ox (w_ox),
        .i_oy (w_oy),
        .i_ax (w_ax),
        .i_ay (w_ay),
        .i_bx (w_bx),
        .i_by (w_by),
        .o_c  (w_c)
    );

    assign w_in_box  = (((w_ax <= r_px) && (r_px <= w_bx)) || ((w_bx <= r_px) && (r_px <= w_ax))) &&
                       (((w_ay <= r_py) && (r_py <= w_by)) || ((w_by <= r_py) && (r_py <= w_ay)));
    assign w_out_nx  = r_out_f  || (!w_c[XW-1] && (w_c != '0));
    assign w_edge_nx = r_edge_f || ((w_c == '0) && w_in_box);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_px      <= '0;
            r_py      <= '0;
            for (int n = 0; n < NV; n++) begin
                r_vx[n] <= '0;
                r_vy[n] <= '0;
            end
            r_cnt     <= '0;
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_out_f   <= 1'b0;
            r_edge_f  <= 1'b0;
            r_inside  <= 1'b0;
            r_on_edge <= 1'b0;
        end else begin
            case (r_state)
                LOAD: if (in_valid) begin
                    if (r_cnt == '0) begin
                        r_px <= X;
                        r_py <= Y;
                    end else begin
                        r_vx[IW'(r_cnt - CW'(1))] <= X;
                        r_vy[IW'(r_cnt - CW'(1))] <= Y;
                    end
                    r_cnt <= r_cnt + CW'(1);
                end
                SORT: begin
                    // Fixed schedule with no early exit keeps the latency independent of the data.
                    if (!w_c[XW-1]) begin
                        r_vx[w_ia] <= w_bx;
                        r_vy[w_ia] <= w_by;
                        r_vx[w_ib] <= w_ax;
                        r_vy[w_ib] <= w_ay;
                    end
                    if (r_j == '0) begin
                        r_i <= r_i + CW'(1);
                        r_j <= r_i + CW'(1);
                    end else begin
                        r_j <= r_j - CW'(1);
                    end
                end
                CHECK: begin
                    r_out_f  <= w_out_nx;
                    r_edge_f <= w_edge_nx;
                    r_k      <= r_k + IW'(1);
                    if (w_check_last) begin
                        if (w_out_nx) begin
                            r_inside  <= 1'b0;
                            r_on_edge <= 1'b0;
                        end else if (w_edge_nx) begin
                            r_inside  <= EDGE_INSIDE;
                            r_on_edge <= 1'b1;
                        end else begin
                            r_inside  <= 1'b1;
                            r_on_edge <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_cnt    <= '0;
                    r_i      <= '0;
                    r_j      <= '0;
                    r_k      <= '0;
                    r_out_f  <= 1'b0;
                    r_edge_f <= 1'b0;
                end
            endcase
        end
    end

    assign is_inside = r_inside;
    assign on_edge   = r_on_edge;

endmodule

// File: tb/tb_geofence_gen.sv
// Directed bench for geofence_gen: hexagon frames on two NV=6 instances
// (EDGE_INSIDE 0 and 1) and triangle frames on an NV=3, W=12 instance.
module tb_geofence_gen;

    logic        clk;
    logic        reset;
    logic        iv6, iv3;
    logic [9:0]  x6, y6;
    logic [11:0] x3, y3;
    logic        busy0, vld0, ins0, edg0;
    logic        busy1, vld1, ins1, edg1;
    logic        busy3, vld3, ins3, edg3;

    int n_chk = 0;
    int n_err = 0;

    int hx[6] = '{10, 2, 8, 0, 8, 2};
    int hy[6] = '{5, 0, 10, 5, 0, 10};
    int tx[6] = '{0, 4000, 0, 0, 0, 0};
    int ty[6] = '{0, 0, 4000, 0, 0, 0};

    geofence_gen #(.W(10), .NV(6), .EDGE_INSIDE(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(iv6), .X(x6), .Y(y6),
        .busy(busy0), .valid(vld0), .is_inside(ins0), .on_edge(edg0)
    );

    geofence_gen #(.W(10), .NV(6), .EDGE_INSIDE(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(iv6), .X(x6), .Y(y6),
        .busy(busy1), .valid(vld1), .is_inside(ins1), .on_edge(edg1)
    );

    geofence_gen #(.W(12), .NV(3), .EDGE_INSIDE(1'b0)) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(iv3), .X(x3), .Y(y3),
        .busy(busy3), .valid(vld3), .is_inside(ins3), .on_edge(edg3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit v, input int x, input int y);
        if (sel) begin
            iv3 = v;
            x3  = 12'(x);
            y3  = 12'(y);
        end else begin
            iv6 = v;
            x6  = 10'(x);
            y6  = 10'(y);
        end
    endtask

    task automatic put(input bit sel, input int x, input int y, input int gap);
        repeat (gap) begin
            @(negedge clk);
            drive(sel, 1'b0, 0, 0);
            @(posedge clk);
        end
        @(negedge clk);
        drive(sel, 1'b1, x, y);
        @(posedge clk);
    endtask

    // Sends P and the vertex list, then measures the valid edge relative to the last vertex edge.
    task automatic frame(input bit sel, input int n, input int px, input int py,
                         input bit gaps, input bit hold, input string tag,
                         input bit exp_in, input bit exp_edge);
        int lat;
        int exp_lat;
        exp_lat = (n - 1) * (n - 2) / 2 + n + 1;
        put(sel, px, py, gaps ? 1 : 0);
        for (int v = 0; v < n; v++)
            put(sel, sel ? tx[v] : hx[v], sel ? ty[v] : hy[v], gaps ? (v % 3) : 0);
        lat = 0;
        for (int m = 0; m < 40 && lat == 0; m++) begin
            @(negedge clk);
            drive(sel, hold, hold ? 777 : 0, hold ? 333 : 0);
            if (m == 0) check({tag, "_busy"}, sel ? busy3 : busy0, 1);
            if ((sel ? vld3 : vld0) === 1'b1) lat = m + 1;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_inside"}, sel ? ins3 : ins0, exp_in);
        check({tag, "_onedge"}, sel ? edg3 : edg0, exp_edge);
        if (!sel) begin
            check({tag, "_vld_e1"}, vld1, 1);
            check({tag, "_inside_e1"}, ins1, exp_edge ? 1'b1 : exp_in);
            check({tag, "_onedge_e1"}, edg1, exp_edge);
        end
        @(negedge clk);
        drive(sel, 1'b0, 0, 0);
        check({tag, "_vld_drop"}, sel ? vld3 : vld0, 0);
        check({tag, "_idle"}, sel ? busy3 : busy0, 0);
        check({tag, "_held"}, sel ? ins3 : ins0, exp_in);
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        drive(1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_busy", busy0, 0);
        check("rst_valid", vld0, 0);
        check("rst_inside", ins0, 0);
        check("rst_onedge", edg0, 0);
        check("rst_valid3", vld3, 0);
        reset = 1'b0;

        frame(1'b0, 6, 5, 5, 1'b0, 1'b0, "hex_in", 1'b1, 1'b0);
        frame(1'b0, 6, 5, 0, 1'b0, 1'b0, "hex_edge", 1'b0, 1'b1);
        frame(1'b0, 6, 20, 20, 1'b0, 1'b0, "hex_far", 1'b0, 1'b0);
        frame(1'b0, 6, 9, 9, 1'b0, 1'b0, "hex_wrap", 1'b0, 1'b0);
        frame(1'b0, 6, 5, 5, 1'b1, 1'b1, "hex_gaphold", 1'b1, 1'b0);
        frame(1'b0, 6, 9, 9, 1'b0, 1'b0, "hex_after_hold", 1'b0, 1'b0);

        // Abort in the fifth SORT cycle.
        put(1'b0, 5, 5, 0);
        for (int v = 0; v < 6; v++) put(1'b0, hx[v], hy[v], 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 0, 0);
        reset = 1'b1;
        #1;
        check("abort_busy", busy0, 0);
        check("abort_valid", vld0, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int m = 0; m < 30; m++) begin
            @(negedge clk);
            if (vld0 === 1'b1) seen++;
        end
        check("abort_no_valid", seen, 0);
        frame(1'b0, 6, 5, 5, 1'b0, 1'b0, "hex_after_rst", 1'b1, 1'b0);

        frame(1'b1, 3, 1000, 1000, 1'b0, 1'b0, "tri_in", 1'b1, 1'b0);
        frame(1'b1, 3, 2000, 2000, 1'b0, 1'b0, "tri_edge", 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
